wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have ports:
- clk  in  1  core clock, all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- rd_valid  in  3  per read port, operand is a register.
- rd_idx  in  3x4  GPR index per read port.
- rd_data  out  3x64  register value per read port.
- rd_conflict  out  1  some valid read port hits a busy register.
- claim_valid  in  1  DF issues a uop that writes claim_idx.
- claim_idx  in  4  destination GPR of issued uop.
- wb_valid  in  1  MEM→WB result valid this cycle.
- wb_reg_en  in  1  result targets a GPR.
- wb_idx  in  4  destination GPR.
- wb_size  in  2  0=8b, 1=16b, 2=32b, 3=64b.
- wb_data  in  64  result, low bits significant.
- wb_flags_en  in  1  uop updates RFLAGS.
- wb_flags  in  64  new RFLAGS.
- rflags  out  64  architectural RFLAGS.
- retired  out  64  count of retired uops.
- sb_error  out  1  sticky scoreboard underflow/overflow.
REQ-002 Parameter NUM_GPR, default 16, number of architectural GPRs.
REQ-003 Parameter SB_MAX, default 3, max in-flight writers per GPR.

Function
REQ-004 SHALL hold NUM_GPR 64-bit registers, one RFLAGS register and a per-GPR 2-bit in-flight counter.
REQ-005 Read ports SHALL be combinational: rd_data = register value, or the merged wb value when wb_valid && wb_reg_en && wb_idx==rd_idx in the same cycle (write-to-read bypass).
REQ-006 GPR write SHALL occur on the edge when wb_valid && wb_reg_en; size rules: 64b full write; 32b writes low 32 and zeroes [63:32]; 16b/8b merge into [15:0]/[7:0], preserving other bits.
REQ-007 RFLAGS SHALL load wb_flags when wb_valid && wb_flags_en, independent of wb_reg_en.
REQ-008 retired SHALL increment by 1 on every edge with wb_valid, wrapping at 2^64.
REQ-009 Counter update per GPR: +1 on claim, -1 on release (wb_valid && wb_reg_en), unchanged when both target the same GPR in one cycle.
REQ-010 rd_conflict SHALL be 1 if any valid port's GPR count is nonzero, except when count==1 and that GPR is released this cycle.
REQ-011 claim at count==SB_MAX (without same-cycle release) SHALL be ignored and set sb_error.
REQ-012 release at count==0 (without same-cycle claim) SHALL leave count 0, still write data, and set sb_error.
REQ-013 sb_error SHALL remain 1 until reset.
REQ-014 Latency: write visible on rd_data same cycle (bypass) and from register the following cycle.

Reset
REQ-015 On reset assertion, asynchronously: all GPRs 0 except RSP=64'h7C00, RFLAGS=64'h2, all counters 0, retired 0, sb_error 0.
REQ-016 Reset mid-operation SHALL discard in-flight claims; no write or claim in the deassertion cycle's edge is lost after reset falls.

Structure
REQ-017 GPR index constants, NUM_GPR, size encoding and RFLAGS reset value SHALL live in the shared package beside the micro-op typedefs.
REQ-018 Counter array and conflict logic SHALL be a sub-module wb_scoreboard; data array and merge stay in wb_regfile.

Verification
REQ-019 Reset -> RSP read =7C00, RAX=0, rflags=2, retired=0, rd_conflict=0.
REQ-020 Write RAX=FFFF_FFFF_FFFF_FFFF size64, then size32 data 1234 -> RAX=0000_0000_0000_1234; then size8 data AB -> 0000_0000_0000_12AB.
REQ-021 Claim RBX; read RBX -> rd_conflict=1; release RBX data 5 same cycle as read -> rd_conflict=0, rd_data=5.
REQ-022 Claim RCX 3 times, 4th claim -> sb_error=1, count stays 3; three releases -> conflict clears only after third.
REQ-023 Release RDX with count 0 -> RDX written, sb_error=1, count 0.
REQ-024 Same-cycle claim+release of RSI at count 1 -> count stays 1, rd_conflict=1 next cycle; 10 wb_valid pulses -> retired=10.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the writeback register file: GPR indices, size
// encoding, reset values and the writeback micro-op view.
package wb_regfile_pkg;

  localparam int DEF_NUM_GPR = 16;
  localparam int DEF_SB_MAX  = 3;
  localparam int IDX_W       = 4;
  localparam int NUM_RD      = 3;

  localparam logic [IDX_W-1:0] GPR_RAX = 4'd0;
  localparam logic [IDX_W-1:0] GPR_RCX = 4'd1;
  localparam logic [IDX_W-1:0] GPR_RDX = 4'd2;
  localparam logic [IDX_W-1:0] GPR_RBX = 4'd3;
  localparam logic [IDX_W-1:0] GPR_RSP = 4'd4;
  localparam logic [IDX_W-1:0] GPR_RBP = 4'd5;
  localparam logic [IDX_W-1:0] GPR_RSI = 4'd6;
  localparam logic [IDX_W-1:0] GPR_RDI = 4'd7;

  localparam logic [63:0] RFLAGS_RST = 64'h2;
  localparam logic [63:0] RSP_RST    = 64'h7C00;

  typedef enum logic [1:0] {
    SZ_8  = 2'd0,
    SZ_16 = 2'd1,
    SZ_32 = 2'd2,
    SZ_64 = 2'd3
  } wb_size_e;

  typedef struct packed {
    logic             valid;
    logic             reg_en;
    logic [IDX_W-1:0] idx;
    wb_size_e         size;
    logic [63:0]      data;
    logic             flags_en;
    logic [63:0]      flags;
  } wb_uop_t;

  // 32-bit results zero-extend; 8/16-bit results keep the untouched upper bits.
  function automatic logic [63:0] merge_wb(input logic [63:0] old_val,
                                           input logic [63:0] data,
                                           input wb_size_e    size);
    logic [63:0] res;
    case (size)
      SZ_8:    res = {old_val[63:8], data[7:0]};
      SZ_16:   res = {old_val[63:16], data[15:0]};
      SZ_32:   res = {32'h0, data[31:0]};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-GPR in-flight writer counters and read-operand conflict detection.
module wb_scoreboard
  import wb_regfile_pkg::*;
#(
  parameter int NUM_GPR = DEF_NUM_GPR,
  parameter int SB_MAX  = DEF_SB_MAX
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    claim_valid,
  input  logic [IDX_W-1:0]        claim_idx,
  input  logic                    rel_valid,
  input  logic [IDX_W-1:0]        rel_idx,
  input  logic [NUM_RD-1:0]       rd_valid,
  input  logic [NUM_RD*IDX_W-1:0] rd_idx,
  output logic                    rd_conflict,
  output logic                    sb_error
);

  logic [1:0]         cnt_q [NUM_GPR];
  logic [1:0]         cnt_d [NUM_GPR];
  logic               err_q, err_d;
  logic [NUM_GPR-1:0] claim_hit, rel_hit;
  logic [IDX_W-1:0]   pidx;
  logic [1:0]         pcnt;

  always_comb begin
    claim_hit = '0;
    rel_hit   = '0;
    for (int i = 0; i < NUM_GPR; i++) begin
      claim_hit[i] = claim_valid && (claim_idx == IDX_W'(i));
      rel_hit[i]   = rel_valid && (rel_idx == IDX_W'(i));
    end
  end

  always_comb begin
    err_d = err_q;
    for (int i = 0; i < NUM_GPR; i++) begin
      cnt_d[i] = cnt_q[i];
      if (claim_hit[i] && !rel_hit[i]) begin
        if (cnt_q[i] == 2'(SB_MAX)) err_d = 1'b1;
        else                        cnt_d[i] = cnt_q[i] + 2'd1;
      end else if (rel_hit[i] && !claim_hit[i]) begin
        if (cnt_q[i] == 2'd0) err_d = 1'b1;
        else                  cnt_d[i] = cnt_q[i] - 2'd1;
      end
    end
  end

  // A last outstanding writer retiring this cycle is covered by the bypass path.
  always_comb begin
    rd_conflict = 1'b0;
    pidx        = '0;
    pcnt        = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      pidx = rd_idx[p*IDX_W +: IDX_W];
      pcnt = (int'(pidx) < NUM_GPR) ? cnt_q[pidx] : 2'd0;
      if (rd_valid[p] && pcnt != 2'd0 &&
          !(pcnt == 2'd1 && rel_valid && rel_idx == pidx))
        rd_conflict = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_GPR; i++) cnt_q[i] <= 2'd0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_GPR; i++) cnt_q[i] <= cnt_d[i];
      err_q <= err_d;
    end
  end

  assign sb_error = err_q;

endmodule

// File: rtl/wb_regfile.sv
// Architectural GPR/RFLAGS state with sized writeback merge, write-to-read
// bypass, retire counter and an in-flight writer scoreboard.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int NUM_GPR = DEF_NUM_GPR,
  parameter int SB_MAX  = DEF_SB_MAX
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_RD-1:0]       rd_valid,
  input  logic [NUM_RD*IDX_W-1:0] rd_idx,
  output logic [NUM_RD*64-1:0]    rd_data,
  output logic                    rd_conflict,
  input  logic                    claim_valid,
  input  logic [IDX_W-1:0]        claim_idx,
  input  logic                    wb_valid,
  input  logic                    wb_reg_en,
  input  logic [IDX_W-1:0]        wb_idx,
  input  logic [1:0]              wb_size,
  input  logic [63:0]             wb_data,
  input  logic                    wb_flags_en,
  input  logic [63:0]             wb_flags,
  output logic [63:0]             rflags,
  output logic [63:0]             retired,
  output logic                    sb_error
);

  wb_uop_t          wb_uop;
  logic [63:0]      gpr_q [NUM_GPR];
  logic [63:0]      gpr_d [NUM_GPR];
  logic [63:0]      rflags_q, rflags_d;
  logic [63:0]      retired_q, retired_d;
  logic             gpr_wr;
  logic [63:0]      wr_old, wr_merged;
  logic [IDX_W-1:0] ridx;
  logic [63:0]      rval;

  assign wb_uop = '{valid:    wb_valid,
                    reg_en:   wb_reg_en,
                    idx:      wb_idx,
                    size:     wb_size_e'(wb_size),
                    data:     wb_data,
                    flags_en: wb_flags_en,
                    flags:    wb_flags};

  assign gpr_wr    = wb_uop.valid && wb_uop.reg_en && (int'(wb_uop.idx) < NUM_GPR);
  assign wr_old    = (int'(wb_uop.idx) < NUM_GPR) ? gpr_q[wb_uop.idx] : '0;
  assign wr_merged = merge_wb(wr_old, wb_uop.data, wb_uop.size);

  always_comb begin
    gpr_d = gpr_q;
    if (gpr_wr) gpr_d[wb_uop.idx] = wr_merged;
    rflags_d  = (wb_uop.valid && wb_uop.flags_en) ? wb_uop.flags : rflags_q;
    retired_d = retired_q + 64'(wb_uop.valid);
  end

  always_comb begin
    rd_data = '0;
    ridx    = '0;
    rval    = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ridx = rd_idx[p*IDX_W +: IDX_W];
      rval = (int'(ridx) < NUM_GPR) ? gpr_q[ridx] : '0;
      if (gpr_wr && wb_uop.idx == ridx) rval = wr_merged;
      rd_data[p*64 +: 64] = rval;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_GPR; i++)
        gpr_q[i] <= (i == int'(GPR_RSP)) ? RSP_RST : 64'h0;
      rflags_q  <= RFLAGS_RST;
      retired_q <= 64'h0;
    end else begin
      gpr_q     <= gpr_d;
      rflags_q  <= rflags_d;
      retired_q <= retired_d;
    end
  end

  assign rflags  = rflags_q;
  assign retired = retired_q;

  wb_scoreboard #(
    .NUM_GPR (NUM_GPR),
    .SB_MAX  (SB_MAX)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .claim_valid (claim_valid),
    .claim_idx   (claim_idx),
    .rel_valid   (wb_uop.valid && wb_uop.reg_en),
    .rel_idx     (wb_uop.idx),
    .rd_valid    (rd_valid),
    .rd_idx      (rd_idx),
    .rd_conflict (rd_conflict),
    .sb_error    (sb_error)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: scenario tasks with a queue of expected values.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   rd_valid;
  logic [11:0]  rd_idx;
  logic [191:0] rd_data;
  logic         rd_conflict;
  logic         claim_valid;
  logic [3:0]   claim_idx;
  logic         wb_valid, wb_reg_en;
  logic [3:0]   wb_idx;
  logic [1:0]   wb_size;
  logic [63:0]  wb_data;
  logic         wb_flags_en;
  logic [63:0]  wb_flags;
  logic [63:0]  rflags, retired;
  logic         sb_error;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;
  logic [63:0] mdl [16];

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset(reset),
    .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_data(rd_data), .rd_conflict(rd_conflict),
    .claim_valid(claim_valid), .claim_idx(claim_idx),
    .wb_valid(wb_valid), .wb_reg_en(wb_reg_en), .wb_idx(wb_idx), .wb_size(wb_size),
    .wb_data(wb_data), .wb_flags_en(wb_flags_en), .wb_flags(wb_flags),
    .rflags(rflags), .retired(retired), .sb_error(sb_error)
  );

  function automatic logic [63:0] model_merge(input logic [63:0] old_v, input logic [63:0] d,
                                              input logic [1:0] sz);
    logic [63:0] m;
    case (sz)
      2'd0:    m = 64'h0000_0000_0000_00FF;
      2'd1:    m = 64'h0000_0000_0000_FFFF;
      2'd2:    return d & 64'h0000_0000_FFFF_FFFF;
      default: return d;
    endcase
    return (old_v & ~m) | (d & m);
  endfunction

  task automatic idle();
    rd_valid = '0; rd_idx = '0; claim_valid = 0; claim_idx = '0;
    wb_valid = 0; wb_reg_en = 0; wb_idx = '0; wb_size = 2'd3; wb_data = '0;
    wb_flags_en = 0; wb_flags = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_rd(input int p, input logic [3:0] idx);
    rd_valid[p] = 1'b1;
    rd_idx[p*4 +: 4] = idx;
  endtask

  task automatic wb(input logic [3:0] idx, input logic [1:0] sz, input logic [63:0] d);
    wb_valid = 1; wb_reg_en = 1; wb_idx = idx; wb_size = sz; wb_data = d;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 16; i++) mdl[i] = 64'h0;
    mdl[4] = 64'h7C00;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    set_rd(0, GPR_RSP); set_rd(1, GPR_RAX);
    #2;
    exp_q.push_back(64'h7C00); exp_q.push_back(64'h0); exp_q.push_back(64'h2);
    exp_q.push_back(64'h0); exp_q.push_back(64'h0);
    checks++; e = exp_q.pop_front();
    if (rd_data[63:0] !== e) begin failures++; $display("FAIL reset_rsp got=%h exp=%h", rd_data[63:0], e); end
    checks++; e = exp_q.pop_front();
    if (rd_data[127:64] !== e) begin failures++; $display("FAIL reset_rax got=%h exp=%h", rd_data[127:64], e); end
    checks++; e = exp_q.pop_front();
    if (rflags !== e) begin failures++; $display("FAIL reset_rflags got=%h exp=%h", rflags, e); end
    checks++; e = exp_q.pop_front();
    if (retired !== e) begin failures++; $display("FAIL reset_retired got=%h exp=%h", retired, e); end
    checks++; e = exp_q.pop_front();
    if ({63'h0, rd_conflict} !== e) begin failures++; $display("FAIL reset_conflict got=%b exp=%0h", rd_conflict, e); end
    tick();
    reset = 0;
  endtask

  task automatic test_sizes();
    do_reset();
    wb(GPR_RAX, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    wb(GPR_RAX, 2'd2, 64'h1234); set_rd(0, GPR_RAX);
    exp_q.push_back(64'h0000_0000_0000_1234);
    #1; checks++; e = exp_q.pop_front();
    if (rd_data[63:0] !== e) begin failures++; $display("FAIL size32_bypass got=%h exp=%h", rd_data[63:0], e); end
    tick();
    wb(GPR_RAX, 2'd0, 64'hAB);
    exp_q.push_back(64'h0000_0000_0000_12AB);
    #1; checks++; e = exp_q.pop_front();
    if (rd_data[63:0] !== e) begin failures++; $display("FAIL size8_bypass got=%h exp=%h", rd_data[63:0], e); end
    tick();
    idle(); set_rd(0, GPR_RAX);
    exp_q.push_back(64'h0000_0000_0000_12AB);
    #1; checks++; e = exp_q.pop_front();
    if (rd_data[63:0] !== e) begin failures++; $display("FAIL size8_reg got=%h exp=%h", rd_data[63:0], e); end
    wb(GPR_RBP, 2'd3, 64'h0123_4567_89AB_CDEF);
    tick();
    wb(GPR_RBP, 2'd1, 64'hFFFF_FFFF_FFFF_BEEF);
    tick();
    wb(GPR_RBP, 2'd0, 64'h5555_5555_5555_5577);
    tick();
    idle(); set_rd(1, GPR_RBP);
    exp_q.push_back(64'h0123_4567_89AB_BE77);
    #1; checks++; e = exp_q.pop_front();
    if (rd_data[127:64] !== e) begin failures++; $display("FAIL size16_8_merge got=%h exp=%h", rd_data[127:64], e); end
    wb_valid = 1; wb_reg_en = 0; wb_idx = GPR_RBP; wb_data = 64'h0; wb_flags_en = 1; wb_flags = 64'hCAFE;
    tick();
    idle(); set_rd(1, GPR_RBP);
    exp_q.push_back(64'hCAFE); exp_q.push_back(64'h0123_4567_89AB_BE77);
    #1; checks++; e = exp_q.pop_front();
    if (rflags !== e) begin failures++; $display("FAIL rflags_load got=%h exp=%h", rflags, e); end
    checks++; e = exp_q.pop_front();
    if (rd_data[127:64] !== e) begin failures++; $display("FAIL flags_only_no_gpr got=%h exp=%h", rd_data[127:64], e); end
  endtask

  task automatic test_conflict_bypass();
    do_reset();
    claim_valid = 1; claim_idx = GPR_RBX;
    tick();
    idle(); rd_idx[11:8] = GPR_RBX;
    #1; exp_q.push_back(64'h0);
    checks++; e = exp_q.pop_front();
    if ({63'h0, rd_conflict} !== e) begin failures++; $display("FAIL conflict_invalid_port got=%b exp=%0h", rd_conflict, e); end
    set_rd(2, GPR_RBX);
    #1; exp_q.push_back(64'h1);
    checks++; e = exp_q.pop_front();
    if ({63'h0, rd_conflict} !== e) begin failures++; $display("FAIL conflict_claimed got=%b exp=%0h", rd_conflict, e); end
    wb(GPR_RBX, 2'd3, 64'h5);
    #1; exp_q.push_back(64'h0); exp_q.push_back(64'h5);
    checks++; e = exp_q.pop_front();
    if ({63'h0, rd_conflict} !== e) begin failures++; $display("FAIL conflict_release got=%b exp=%0h", rd_conflict, e); end
    checks++; e = exp_q.pop_front();
    if (rd_data[191:128] !== e) begin failures++; $display("FAIL bypass_rbx got=%h exp=%h", rd_data[191:128], e); end
    tick();
    idle(); set_rd(2, GPR_RBX);
    #1; exp_q.push_back(64'h5); exp_q.push_back(64'h0);
    checks++; e = exp_q.pop_front();
    if (rd_data[191:128] !== e) begin failures++; $display("FAIL reg_rbx got=%h exp=%h", rd_data[191:128], e); end
    checks++; e = exp_q.pop_front();
    if ({63'h0, sb_error} !== e) begin failures++; $display("FAIL rbx_no_error got=%b exp=%0h", sb_error, e); end
  endtask

  task automatic test_sb_overflow();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      claim_valid = 1; claim_idx = GPR_RCX;
      tick();
    end
    idle();
    #1; exp_q.push_back(64'h0);
    checks++; e = exp_q.pop_front();
    if ({63'h0, sb_error} !== e) begin failures++; $display("FAIL three_claims_error got=%b exp=%0h", sb_error, e); end
    claim_valid = 1; claim_idx = GPR_RCX;
    tick();
    idle(); set_rd(1, GPR_RCX);
    #1; exp_q.push_back(64'h1);
    checks++; e = exp_q.pop_front();
    if ({63'h0, sb_error} !== e) begin failures++; $display("FAIL overflow_error got=%b exp=%0h", sb_error, e); end
    for (int k = 1; k <= 3; k++) begin
      wb(GPR_RCX, 2'd3, 64'(k));
      tick();
      wb_valid = 0; wb_reg_en = 0;
      #1; exp_q.push_back((k == 3) ? 64'h0 : 64'h1);
      checks++; e = exp_q.pop_front();
      if ({63'h0, rd_conflict} !== e) begin failures++; $display("FAIL overflow_release%0d got=%b exp=%0h", k, rd_conflict, e); end
    end
  endtask

  task automatic test_sb_underflow();
    do_reset();
    wb(GPR_RDX, 2'd3, 64'h99);
    tick();
    idle(); set_rd(0, GPR_RDX);
    #1; exp_q.push_back(64'h1); exp_q.push_back(64'h99); exp_q.push_back(64'h0);
    checks++; e = exp_q.pop_front();
    if ({63'h0, sb_error} !== e) begin failures++; $display("FAIL underflow_error got=%b exp=%0h", sb_error, e); end
    checks++; e = exp_q.pop_front();
    if (rd_data[63:0] !== e) begin failures++; $display("FAIL underflow_data got=%h exp=%h", rd_data[63:0], e); end
    checks++; e = exp_q.pop_front();
    if ({63'h0, rd_conflict} !== e) begin failures++; $display("FAIL underflow_conflict got=%b exp=%0h", rd_conflict, e); end
    claim_valid = 1; claim_idx = GPR_RDX;
    tick();
    claim_valid = 0;
    wb(GPR_RDX, 2'd3, 64'h1);
    tick();
    idle(); set_rd(0, GPR_RDX);
    #1; exp_q.push_back(64'h0); exp_q.push_back(64'h1);
    checks++; e = exp_q.pop_front();
    if ({63'h0, rd_conflict} !== e) begin failures++; $display("FAIL underflow_count0 got=%b exp=%0h", rd_conflict, e); end
    checks++; e = exp_q.pop_front();
    if ({63'h0, sb_error} !== e) begin failures++; $display("FAIL error_sticky got=%b exp=%0h", sb_error, e); end
  endtask

  task automatic test_claim_release_same();
    do_reset();
    claim_valid = 1; claim_idx = GPR_RSI;
    tick();
    wb(GPR_RSI, 2'd3, 64'h7);
    tick();
    idle(); set_rd(0, GPR_RSI);
    #1; exp_q.push_back(64'h1); exp_q.push_back(64'h7); exp_q.push_back(64'h0);
    checks++; e = exp_q.pop_front();
    if ({63'h0, rd_conflict} !== e) begin failures++; $display("FAIL same_cycle_conflict got=%b exp=%0h", rd_conflict, e); end
    checks++; e = exp_q.pop_front();
    if (rd_data[63:0] !== e) begin failures++; $display("FAIL same_cycle_data got=%h exp=%h", rd_data[63:0], e); end
    checks++; e = exp_q.pop_front();
    if ({63'h0, sb_error} !== e) begin failures++; $display("FAIL same_cycle_error got=%b exp=%0h", sb_error, e); end
    wb(GPR_RSI, 2'd3, 64'h8);
    tick();
    wb_valid = 0; wb_reg_en = 0;
    #1; exp_q.push_back(64'h0);
    checks++; e = exp_q.pop_front();
    if ({63'h0, rd_conflict} !== e) begin failures++; $display("FAIL same_cycle_drain got=%b exp=%0h", rd_conflict, e); end
  endtask

  task automatic test_retired();
    int n;
    do_reset();
    n = 0;
    for (int k = 0; k < 20; k++) begin
      wb_valid = (k % 2 == 0);
      if (wb_valid) n++;
      tick();
    end
    idle();
    exp_q.push_back(64'(n));
    #1; checks++; e = exp_q.pop_front();
    if (retired !== e) begin failures++; $display("FAIL retired_count got=%0d exp=%0d", retired, e); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    claim_valid = 1; claim_idx = GPR_RDI;
    tick();
    idle(); wb(GPR_RBP, 2'd3, 64'h1111); wb_flags_en = 1; wb_flags = 64'hFF;
    tick();
    idle();
    #2 reset = 1;
    set_rd(0, GPR_RDI); set_rd(1, GPR_RBP);
    #1; exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h2);
    checks++; e = exp_q.pop_front();
    if ({63'h0, rd_conflict} !== e) begin failures++; $display("FAIL async_conflict got=%b exp=%0h", rd_conflict, e); end
    checks++; e = exp_q.pop_front();
    if (rd_data[127:64] !== e) begin failures++; $display("FAIL async_rbp got=%h exp=%h", rd_data[127:64], e); end
    checks++; e = exp_q.pop_front();
    if (rflags !== e) begin failures++; $display("FAIL async_rflags got=%h exp=%h", rflags, e); end
    tick();
    reset = 0;
    claim_valid = 1; claim_idx = GPR_RDI; wb(GPR_RBP, 2'd3, 64'h2222);
    tick();
    idle(); set_rd(0, GPR_RDI); set_rd(1, GPR_RBP);
    #1; exp_q.push_back(64'h1); exp_q.push_back(64'h2222);
    checks++; e = exp_q.pop_front();
    if ({63'h0, rd_conflict} !== e) begin failures++; $display("FAIL post_reset_claim got=%b exp=%0h", rd_conflict, e); end
    checks++; e = exp_q.pop_front();
    if (rd_data[127:64] !== e) begin failures++; $display("FAIL post_reset_write got=%h exp=%h", rd_data[127:64], e); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ri, oi;
    logic [1:0]  sz;
    logic [63:0] d, nv;
    int          n;
    do_reset();
    n = 0;
    for (int k = 0; k < 24; k++) begin
      idle();
      ri = 4'($urandom_range(0, 15));
      oi = 4'($urandom_range(0, 15));
      sz = 2'($urandom_range(0, 3));
      d  = {$urandom, $urandom};
      nv = model_merge(mdl[ri], d, sz);
      wb(ri, sz, d);
      set_rd(0, ri); set_rd(1, oi);
      exp_q.push_back(nv);
      exp_q.push_back((oi == ri) ? nv : mdl[oi]);
      #1; checks++; e = exp_q.pop_front();
      if (rd_data[63:0] !== e) begin failures++; $display("FAIL b2b_bypass k=%0d got=%h exp=%h", k, rd_data[63:0], e); end
      checks++; e = exp_q.pop_front();
      if (rd_data[127:64] !== e) begin failures++; $display("FAIL b2b_other k=%0d got=%h exp=%h", k, rd_data[127:64], e); end
      mdl[ri] = nv;
      n++;
      tick();
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      set_rd(2, 4'(i));
      exp_q.push_back(mdl[i]);
      #1; checks++; e = exp_q.pop_front();
      if (rd_data[191:128] !== e) begin failures++; $display("FAIL b2b_final r%0d got=%h exp=%h", i, rd_data[191:128], e); end
    end
    exp_q.push_back(64'(n));
    checks++; e = exp_q.pop_front();
    if (retired !== e) begin failures++; $display("FAIL b2b_retired got=%0d exp=%0d", retired, e); end
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_sizes();
    test_conflict_bypass();
    test_sb_overflow();
    test_sb_underflow();
    test_claim_release_same();
    test_retired();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
